sprite_attr_scanner: RTL and testbench

- Per-scanline sprite attribute fetch engine on the read-only port of the sprite attribute dual-port RAM; the CPU writes the other port.
- On each line start it walks all sprite entries and tests each for vertical hit on the current line.
- Each hit sprite is handed to the downstream sprite line-buffer renderer with a valid/ready handshake.

---
 rtl/sprite_attr_scanner.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_attr_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_attr_scanner.sv
// rtl/sprite_attr_scanner.sv - per-scanline sprite attribute fetch and vertical hit scanner; optional per-line record limit under SPR_LIMIT_EN
module sprite_attr_scanner #(
  parameter int ADDR_W   = 7,
  parameter int SPR_CNT  = 24,
  parameter int MAX_HITS = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [7:0]        line,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  input  logic [7:0]        ram_q,
  output logic              spr_valid,
  input  logic              spr_ready,
  output logic [7:0]        spr_code,
  output logic [7:0]        spr_attr,
  output logic [7:0]        spr_x,
  output logic [4:0]        spr_yoff,
  output logic              busy,
`ifdef SPR_LIMIT_EN
  output logic              overflow,
`endif
  output logic              done
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPR_CNT - 1);

  // Reject parameter sets the entry index or the limit counter cannot represent.
  if (SPR_CNT < 1 || SPR_CNT > (1 << IDX_W) || MAX_HITS < 1) begin : g_param_check
    $error("sprite_attr_scanner: SPR_CNT or MAX_HITS out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_EMIT,
    S_NEXT
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [IDX_W-1:0] idx;
  logic [2:0]       k;
  logic [7:0]       line_q;
  logic [7:0]       byte0;
  logic [7:0]       byte1;
  logic [7:0]       byte2;
  logic [7:0]       byte3;
  logic [7:0]       yoff;
  logic             hit;
  logic             last;
  logic             advance;
  logic             finish;

`ifdef SPR_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_HITS + 1);
  logic [CNT_W-1:0] hit_cnt;
  logic             limit_stop;
`endif

  // Vertical hit test: 8-bit wrap-around distance from the sprite top to the latched line.
  always_comb begin
    yoff = line_q - byte2;
    hit  = yoff < (byte1[7] ? 8'd32 : 8'd16);
    last = (idx == LAST_IDX);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; a miss resolves the next entry directly from CHECK so it costs no extra cycle.
  always_comb begin
    state_d = state;
    advance = 1'b0;
    finish  = 1'b0;
`ifdef SPR_LIMIT_EN
    limit_stop = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (line_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (k == 3'd4) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (hit) begin
          state_d = S_EMIT;
        end else if (last) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else begin
          advance = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EMIT: begin
        if (spr_ready) begin
          state_d = S_NEXT;
`ifdef SPR_LIMIT_EN
          if (hit_cnt == CNT_W'(MAX_HITS - 1)) begin
            limit_stop = 1'b1;
            finish     = 1'b1;
            state_d    = S_IDLE;
          end
`endif
        end
      end
      S_NEXT: begin
        if (last) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else begin
          advance = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new line start always wins: abandon the current scan and restart at entry 0.
    if (line_start && state != S_IDLE) begin
      state_d = S_FETCH;
      advance = 1'b0;
      finish  = 1'b0;
`ifdef SPR_LIMIT_EN
      limit_stop = 1'b0;
`endif
    end
  end

  // Datapath: latched line, entry index, fetch sub-counter, captured entry bytes and done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_q <= '0;
      idx    <= '0;
      k      <= '0;
      byte0  <= '0;
      byte1  <= '0;
      byte2  <= '0;
      byte3  <= '0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (line_start) begin
        line_q <= line;
        idx    <= '0;
        k      <= '0;
      end else begin
        if (state == S_FETCH) begin
          k <= k + 3'd1;
          case (k)
            3'd1:    byte0 <= ram_q;
            3'd2:    byte1 <= ram_q;
            3'd3:    byte2 <= ram_q;
            3'd4:    byte3 <= ram_q;
            default: ;
          endcase
        end else begin
          k <= '0;
        end
        if (advance) idx <= idx + 1'b1;
      end
    end
  end

`ifdef SPR_LIMIT_EN
  // Per-line transfer count; overflow flags that entries were left unscanned when the limit hit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      overflow <= 1'b0;
    end else if (line_start) begin
      hit_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == S_EMIT && spr_ready) hit_cnt <= hit_cnt + 1'b1;
      if (limit_stop) overflow <= !last;
    end
  end
`endif

  assign ram_en    = (state == S_FETCH) && (k <= 3'd3);
  assign ram_addr  = ram_en ? {idx, k[1:0]} : '0;
  assign busy      = (state != S_IDLE);
  assign spr_valid = (state == S_EMIT);
  assign spr_code  = byte0;
  assign spr_attr  = byte1;
  assign spr_x     = byte3;
  assign spr_yoff  = yoff[4:0];

endmodule

// File: tb/tb_sprite_attr_scanner.sv
// tb/tb_sprite_attr_scanner.sv - self-checking bench for sprite_attr_scanner
module tb_sprite_attr_scanner;

  localparam int ADDR_W  = 7;
  localparam int SPR_CNT = 24;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              line_start = 1'b0;
  logic [7:0]        line = 8'h00;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic [7:0]        ram_q = 8'h00;
  logic              spr_valid;
  logic              spr_ready = 1'b0;
  logic [7:0]        spr_code;
  logic [7:0]        spr_attr;
  logic [7:0]        spr_x;
  logic [4:0]        spr_yoff;
  logic              busy;
  logic              done;
`ifdef SPR_LIMIT_EN
  logic              overflow;
`endif

  int tests = 0;
  int failed = 0;

  logic [7:0]  mem [0:127];
  logic [28:0] got[$];
  logic [28:0] exp_q[$];
  int          exp_cycles;

  sprite_attr_scanner #(.ADDR_W(ADDR_W), .SPR_CNT(SPR_CNT), .MAX_HITS(8)) dut (
    .clock(clock), .reset_n(reset_n), .line_start(line_start), .line(line),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_q(ram_q),
    .spr_valid(spr_valid), .spr_ready(spr_ready),
    .spr_code(spr_code), .spr_attr(spr_attr), .spr_x(spr_x), .spr_yoff(spr_yoff),
    .busy(busy),
`ifdef SPR_LIMIT_EN
    .overflow(overflow),
`endif
    .done(done)
  );

  always #5 clock = ~clock;

  // Synchronous-read attribute RAM.
  always @(posedge clock) begin
    if (ram_en) ram_q <= mem[ram_addr];
  end

  // Record every handshake transfer.
  always @(negedge clock) begin
    if (reset_n && spr_valid && spr_ready) got.push_back({spr_code, spr_attr, spr_x, spr_yoff});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every entry whose wrapped row distance fits its height yields one record.
  function automatic void build_expect(input logic [7:0] ln);
    exp_q.delete();
    exp_cycles = 0;
    for (int i = 0; i < SPR_CNT; i++) begin
      logic [7:0] d;
      int         h;
      d = ln - mem[4*i+2];
      h = mem[4*i+1][7] ? 32 : 16;
      if (int'(d) < h) begin
        exp_q.push_back({mem[4*i], mem[4*i+1], mem[4*i+3], d[4:0]});
        exp_cycles += 8;
      end else begin
        exp_cycles += 6;
      end
    end
  endfunction

  task automatic fill(input logic [7:0] y);
    for (int i = 0; i < 128; i++) mem[i] = (i % 4 == 2) ? y : 8'h00;
  endtask

  task automatic set_entry(input int e, input logic [7:0] c, input logic [7:0] a,
                           input logic [7:0] y, input logic [7:0] x);
    mem[4*e] = c; mem[4*e+1] = a; mem[4*e+2] = y; mem[4*e+3] = x;
  endtask

  // Counts cycles from the current one until done; lat = 0 means done in this cycle.
  task automatic wait_done(input bit rand_ready, output int lat);
    lat = 0;
    while (lat < 4000 && !done) begin
      if (rand_ready) spr_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
      lat++;
    end
    if (lat >= 4000) check("done_timeout", 1, 0);
  endtask

  // Pulse line_start, then scramble line to show only the latched value matters.
  task automatic run_scan(input logic [7:0] ln, input bit rand_ready, output int lat);
    got.delete();
    @(posedge clock); #1;
    line = ln; line_start = 1'b1;
    spr_ready = 1'b1;
    @(posedge clock); #1;
    line_start = 1'b0;
    line = 8'($urandom);
    wait_done(rand_ready, lat);
    spr_ready = 1'b1;
  endtask

  typedef struct {
    logic [7:0] ln;
    logic [7:0] fill_y;
    logic [7:0] c, a, y, x;
    int         hits;
    int         cycles;
    logic [7:0] e_code;
    logic [7:0] e_x;
    logic [4:0] e_yoff;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    logic [28:0] held;

    vecs[0] = '{8'h2F, 8'hF0, 8'h41, 8'h80, 8'h10, 8'h60,  1, 146, 8'h41, 8'h60, 5'd31};
    vecs[1] = '{8'h30, 8'hF0, 8'h41, 8'h80, 8'h10, 8'h60,  0, 144, 8'h00, 8'h00, 5'd0};
    vecs[2] = '{8'h10, 8'hF0, 8'h22, 8'h00, 8'h10, 8'h33,  1, 146, 8'h22, 8'h33, 5'd0};
    vecs[3] = '{8'h1F, 8'hF0, 8'h22, 8'h00, 8'h10, 8'h33,  1, 146, 8'h22, 8'h33, 5'd15};
    vecs[4] = '{8'h20, 8'hF0, 8'h22, 8'h00, 8'h10, 8'h33,  0, 144, 8'h00, 8'h00, 5'd0};
    vecs[5] = '{8'h04, 8'hF0, 8'h7E, 8'h00, 8'hFA, 8'h11,  1, 146, 8'h7E, 8'h11, 5'd10};
    vecs[6] = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24, 192, 8'h00, 8'h00, 5'd5};

    fill(8'h00);

    // Reset state, during and after reset.
    repeat (3) @(posedge clock);
    #1;
    check("reset_in", {busy, spr_valid, done, ram_en, ram_addr}, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("reset_idle", {busy, spr_valid, done, ram_en}, 0);
    end

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].fill_y);
      set_entry(3, vecs[v].c, vecs[v].a, vecs[v].y, vecs[v].x);
      run_scan(vecs[v].ln, 1'b0, lat);
      check($sformatf("vec%0d_count", v), got.size(), vecs[v].hits);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].cycles);
      if (vecs[v].hits > 0 && got.size() > 0)
        check($sformatf("vec%0d_rec", v), {got[0][28:21], got[0][12:0]},
              {vecs[v].e_code, vecs[v].e_x, vecs[v].e_yoff});
    end

    // Backpressure: record must hold for 10 stalled cycles and transfer exactly once.
    fill(8'hF0);
    set_entry(3, 8'h41, 8'h80, 8'h10, 8'h60);
    got.delete();
    @(posedge clock); #1;
    line = 8'h2F; line_start = 1'b1; spr_ready = 1'b0;
    @(posedge clock); #1;
    line_start = 1'b0;
    lat = 0;
    while (!spr_valid && lat < 400) begin @(posedge clock); #1; lat++; end
    check("bp_valid_seen", spr_valid, 1);
    held = {spr_code, spr_attr, spr_x, spr_yoff};
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("bp_valid_hold", spr_valid, 1);
      check("bp_fields_hold", {spr_code, spr_attr, spr_x, spr_yoff}, held);
    end
    spr_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_valid_drop", spr_valid, 0);
    wait_done(1'b0, lat);
    check("bp_one_transfer", got.size(), 1);
    if (got.size() > 0) check("bp_record", got[0], {8'h41, 8'h80, 8'h60, 5'd31});

    // Abort during EMIT of entry 2.
    fill(8'h00);
    got.delete();
    @(posedge clock); #1;
    line = 8'h05; line_start = 1'b1; spr_ready = 1'b1;
    @(posedge clock); #1;
    line_start = 1'b0;
    lat = 0;
    while (got.size() < 2 && lat < 400) begin @(posedge clock); #1; lat++; end
    spr_ready = 1'b0;
    lat = 0;
    while (!spr_valid && lat < 400) begin @(posedge clock); #1; lat++; end
    check("abort_valid_seen", spr_valid, 1);
    line_start = 1'b1;
    @(posedge clock); #1;
    line_start = 1'b0;
    check("abort_valid_off", spr_valid, 0);
    check("abort_restart", {busy, ram_en, ram_addr}, {1'b1, 1'b1, 7'd0});
    spr_ready = 1'b1;
    wait_done(1'b0, lat);
    check("abort_rescan_latency", lat, 192);
    check("abort_transfers", got.size(), 26);
    if (got.size() > 2) check("abort_rescan_first", got[2], {8'h00, 8'h00, 8'h00, 5'd5});

    // Randomised scans against the reference model.
    for (int r = 0; r < 8; r++) begin
      logic [7:0] ln;
      bit         rr;
      ln = 8'($urandom);
      rr = r[0];
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < SPR_CNT; i++) mem[4*i+2] = ln - 8'($urandom_range(0, 48));
      build_expect(ln);
      run_scan(ln, rr, lat);
      check($sformatf("rand%0d_count", r), got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
        check($sformatf("rand%0d_rec%0d", r, i), got[i], exp_q[i]);
      if (!rr) check($sformatf("rand%0d_latency", r), lat, exp_cycles);
    end

    // Asynchronous reset mid-scan.
    fill(8'h00);
    got.delete();
    @(posedge clock); #1;
    line = 8'h05; line_start = 1'b1; spr_ready = 1'b1;
    @(posedge clock); #1;
    line_start = 1'b0;
    repeat (20) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset", {busy, spr_valid, done, ram_en, ram_addr, spr_yoff}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("async_reset_idle", {busy, spr_valid, done}, 0);

`ifdef SPR_LIMIT_EN
    fill(8'h00);
    run_scan(8'h05, 1'b0, lat);
    check("limit_transfers", got.size(), 8);
    check("limit_latency", lat, 63);
    check("limit_overflow", overflow, 1);
    repeat (3) @(posedge clock);
    #1;
    check("limit_overflow_hold", overflow, 1);
    fill(8'hF0);
    run_scan(8'h30, 1'b0, lat);
    check("limit_no_hits", got.size(), 0);
    check("limit_overflow_clear", overflow, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
